// File: rtl/apb_pkg.sv
// Shared definitions for the APB requester: FSM state encoding and the
// register map of the UART APB top that this requester programs.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_e;

    localparam logic [31:0] ADDR_CTRL_REG  = 32'd0;
    localparam logic [31:0] ADDR_STATS_REG = 32'd1;
    localparam logic [31:0] ADDR_TX_REG    = 32'd2;
    localparam logic [31:0] ADDR_RX_REG    = 32'd3;

endpackage

// File: rtl/apb_master_ctrl.sv
// APB requester: turns a valid/ready command stream into APB SETUP/ACCESS
// transfers, one at a time, with wait-state support, a saturating timeout
// counter and exactly one registered response per accepted command.
module apb_master_ctrl
    import apb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    apb_state_e       state_q;
    apb_state_e       state_d;
    logic [CNT_W-1:0] wait_cnt_q;
    logic [CNT_W-1:0] wait_cnt_d;
    logic             accept;
    logic             complete;
    logic             timeout_hit;

    assign accept = cmd_valid && cmd_ready;

    // Next-state, bus strobes and completion decode; cmd_ready looks only at state and PREADY
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        cmd_ready   = 1'b0;
        PSEL        = 1'b0;
        PENABLE     = 1'b0;
        complete    = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                PSEL       = 1'b1;
                state_d    = ACCESS;
                wait_cnt_d = '0;
            end
            ACCESS: begin
                PSEL      = 1'b1;
                PENABLE   = 1'b1;
                cmd_ready = PREADY;
                if (PREADY) begin
                    complete = 1'b1;
                    state_d  = cmd_valid ? SETUP : IDLE;
                end else if (wait_cnt_q == CNT_W'(TIMEOUT)) begin
                    complete    = 1'b1;
                    timeout_hit = 1'b1;
                    state_d     = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, wait counter, latched command and registered response; reset aborts silently
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            PWRITE     <= 1'b0;
            PADDR      <= '0;
            PWDATA     <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rsp_valid  <= complete;
            if (accept) begin
                PWRITE <= cmd_write;
                PADDR  <= cmd_addr;
                PWDATA <= cmd_wdata;
            end
            if (complete) begin
                rsp_err   <= timeout_hit;
                rsp_rdata <= (timeout_hit || PWRITE) ? '0 : PRDATA;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Self-checking bench for apb_master_ctrl: directed scenarios plus random
// transactions checked against a transaction-level latency/response model.
module tb_apb_master_ctrl;
    import apb_pkg::*;

    localparam int TO = 16;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA = '0;
    logic        PREADY = 1'b0;

    int checks = 0;
    int passes = 0;

    apb_master_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    // Free-running bus clock
    always #5 PCLK = ~PCLK;

    // Hard stop in case something wedges the stimulus sequence
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed still running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic checkBit(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) passes++;
        else $error("[TB] FAIL %s: observed %0b expected %0b", tag, observed, expected);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    task automatic checkAllZero(input string tag);
        checkBit({tag, "_psel"}, PSEL, 1'b0);
        checkBit({tag, "_penable"}, PENABLE, 1'b0);
        checkBit({tag, "_pwrite"}, PWRITE, 1'b0);
        checkOutput({tag, "_paddr"}, PADDR, 32'h0);
        checkOutput({tag, "_pwdata"}, PWDATA, 32'h0);
        checkBit({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        checkOutput({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
        checkBit({tag, "_rsp_err"}, rsp_err, 1'b0);
        checkBit({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    endtask

    // One isolated transaction. The model: the slave holds PREADY low for
    // 'waits' ACCESS cycles; if that exceeds TIMEOUT the transfer dies after
    // TIMEOUT+1 ACCESS cycles with an error. Response arrives the cycle after.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                 input int waits, input logic [31:0] rdata);
        int          nAccess;
        logic        expErr;
        logic [31:0] expRdata;
        expErr   = (waits > TO);
        nAccess  = expErr ? TO + 1 : waits + 1;
        expRdata = (expErr || wr) ? 32'h0 : rdata;

        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
        PREADY = 1'b0; PRDATA = $urandom;
        #1;
        checkBit("idle_cmd_ready", cmd_ready, 1'b1);
        checkBit("idle_psel", PSEL, 1'b0);
        tick();

        cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = $urandom; cmd_wdata = $urandom;
        #1;
        checkBit("setup_psel", PSEL, 1'b1);
        checkBit("setup_penable", PENABLE, 1'b0);
        checkBit("setup_cmd_ready", cmd_ready, 1'b0);
        checkBit("setup_pwrite", PWRITE, wr);
        checkOutput("setup_paddr", PADDR, addr);
        checkOutput("setup_pwdata", PWDATA, wdata);
        tick();

        for (int k = 0; k < nAccess; k++) begin
            PREADY = (k == waits);
            PRDATA = (k == waits) ? rdata : $urandom;
            #1;
            checkBit("access_psel", PSEL, 1'b1);
            checkBit("access_penable", PENABLE, 1'b1);
            checkBit("access_pwrite", PWRITE, wr);
            checkOutput("access_paddr", PADDR, addr);
            checkOutput("access_pwdata", PWDATA, wdata);
            checkBit("access_rsp_valid", rsp_valid, 1'b0);
            checkBit("access_cmd_ready", cmd_ready, PREADY);
            tick();
        end

        PREADY = 1'b0; PRDATA = $urandom;
        #1;
        checkBit("rsp_valid", rsp_valid, 1'b1);
        checkBit("rsp_err", rsp_err, expErr);
        checkOutput("rsp_rdata", rsp_rdata, expRdata);
        checkBit("rsp_psel", PSEL, 1'b0);
        checkBit("rsp_cmd_ready", cmd_ready, 1'b1);
        checkOutput("hold_paddr", PADDR, addr);
        tick();
        checkBit("rsp_pulse_end", rsp_valid, 1'b0);
        checkOutput("rsp_rdata_hold", rsp_rdata, expRdata);
        checkBit("rsp_err_hold", rsp_err, expErr);
    endtask

    initial begin
        logic        rWr;
        logic [31:0] rAddr;
        logic [31:0] rData;
        logic [31:0] rRd;
        int          rWaits;

        // Reset state
        PRESET = 1'b1;
        tick();
        tick();
        PRESET = 1'b0;
        #1;
        checkAllZero("reset");

        // Write after reset, zero wait states
        applyStimulus(1'b1, ADDR_CTRL_REG, 32'h6, 0, 32'h0);
        // Read with slave data
        applyStimulus(1'b0, ADDR_RX_REG, 32'h0, 0, 32'hA5);
        // Three wait states
        applyStimulus(1'b0, ADDR_STATS_REG, 32'h0, 3, 32'h1234_5678);
        // Completion exactly on the last allowed ACCESS cycle
        applyStimulus(1'b0, ADDR_RX_REG, 32'h0, TO, 32'hCAFE_0001);
        // Timeout with PREADY stuck low
        applyStimulus(1'b0, ADDR_RX_REG, 32'h0, 1000, 32'hDEAD_BEEF);

        // Back-to-back writes with cmd_valid held and PREADY tied high
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = ADDR_CTRL_REG; cmd_wdata = 32'h8;
        PREADY = 1'b1;
        tick();
        cmd_addr = ADDR_TX_REG; cmd_wdata = 32'h91;
        #1;
        checkBit("b2b_setup1_penable", PENABLE, 1'b0);
        checkOutput("b2b_setup1_pwdata", PWDATA, 32'h8);
        checkBit("b2b_setup1_ready", cmd_ready, 1'b0);
        tick();
        checkBit("b2b_access1_penable", PENABLE, 1'b1);
        checkBit("b2b_access1_ready", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
        #1;
        checkBit("b2b_setup2_psel", PSEL, 1'b1);
        checkBit("b2b_setup2_penable", PENABLE, 1'b0);
        checkOutput("b2b_setup2_paddr", PADDR, ADDR_TX_REG);
        checkOutput("b2b_setup2_pwdata", PWDATA, 32'h91);
        checkBit("b2b_rsp1_valid", rsp_valid, 1'b1);
        checkBit("b2b_rsp1_err", rsp_err, 1'b0);
        tick();
        checkBit("b2b_access2_penable", PENABLE, 1'b1);
        checkBit("b2b_gap_rsp_valid", rsp_valid, 1'b0);
        tick();
        checkBit("b2b_rsp2_valid", rsp_valid, 1'b1);
        checkOutput("b2b_rsp2_rdata", rsp_rdata, 32'h0);
        checkBit("b2b_end_psel", PSEL, 1'b0);
        PREADY = 1'b0;
        tick();

        // Reset asserted during an ACCESS wait state
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = ADDR_TX_REG; cmd_wdata = 32'h55;
        PREADY = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        checkBit("abort_in_access", PENABLE, 1'b1);
        PRESET = 1'b1;
        tick();
        PRESET = 1'b0;
        #1;
        checkAllZero("abort");
        for (int i = 0; i < TO + 4; i++) begin
            tick();
            checkBit("abort_no_rsp", rsp_valid, 1'b0);
        end
        applyStimulus(1'b1, ADDR_TX_REG, 32'h77, 1, 32'h0);

        // Random transactions against the model
        for (int i = 0; i < 25; i++) begin
            rWr    = 1'($urandom_range(0, 1));
            rAddr  = $urandom;
            rData  = $urandom;
            rRd    = $urandom;
            rWaits = ($urandom_range(0, 7) == 0) ? TO + 1 + int'($urandom_range(0, 4))
                                                 : int'($urandom_range(0, 5));
            applyStimulus(rWr, rAddr, rData, rWaits, rRd);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
